// File: rtl/pattern_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package pattern_detect_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Bits needed to hold a length value in the range 0..max_len.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/pattern_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Count register: clear, or step up until all ones and hold there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_detect_prog.sv
// Programmable serial pattern detector with overlap control and a saturating match counter.
module pattern_detect_prog
   import pattern_detect_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cfg_wr,
   input  logic [MAX_LEN-1:0]            cfg_pattern,
   input  logic [len_w(MAX_LEN)-1:0]     cfg_len,
   input  logic                          cfg_overlap,
   input  logic                          in_valid,
   input  logic                          in_bit,
   output logic                          match,
   output logic [CNT_W-1:0]              match_count,
   output logic                          cfg_err,
   output logic                          armed
);

   localparam int LW = len_w(MAX_LEN);
   localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

   state_t               state, state_nxt;
   logic [MAX_LEN-1:0]   hist, hist_nxt;
   logic [LW-1:0]        fill, fill_nxt;
   logic [MAX_LEN-1:0]   pat, pat_nxt;
   logic [LW-1:0]        len, len_nxt;
   logic                 ovl, ovl_nxt;
   logic                 match_nxt, cfg_err_nxt;
   logic                 cnt_inc, cnt_clr;

   logic                 cfg_ok;
   logic [MAX_LEN-1:0]   hist_sh;
   logic [LW-1:0]        fill_inc;
   logic [MAX_LEN-1:0]   len_mask;
   logic                 hit;

   // Candidate history/fill for an accepted bit and the compare against the pattern.
   always_comb begin
      cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
      hist_sh  = {hist[MAX_LEN-2:0], in_bit};
      fill_inc = (fill == LEN_MAX) ? fill : fill + 1'b1;
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LW'(i) < len);
      end
      hit = (((hist_sh ^ pat) & len_mask) == '0) && (fill_inc >= len);
   end

   // Next-state logic: configuration writes win over data; data only advances when armed.
   always_comb begin
      state_nxt   = state;
      hist_nxt    = hist;
      fill_nxt    = fill;
      pat_nxt     = pat;
      len_nxt     = len;
      ovl_nxt     = ovl;
      match_nxt   = 1'b0;
      cfg_err_nxt = 1'b0;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b0;
      if (cfg_wr) begin
         if (cfg_ok) begin
            pat_nxt   = cfg_pattern;
            len_nxt   = cfg_len;
            ovl_nxt   = cfg_overlap;
            hist_nxt  = '0;
            fill_nxt  = '0;
            cnt_clr   = 1'b1;
            state_nxt = FILL;
         end else begin
            cfg_err_nxt = 1'b1;
         end
      end else begin
         case (state)
            IDLE: state_nxt = IDLE;
            FILL, RUN: begin
               if (in_valid) begin
                  hist_nxt = hist_sh;
                  fill_nxt = fill_inc;
                  if (hit) begin
                     match_nxt = 1'b1;
                     cnt_inc   = 1'b1;
                     if (!ovl) fill_nxt = '0;
                  end
                  state_nxt = (fill_nxt >= len) ? RUN : FILL;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State, configuration and output pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         hist    <= '0;
         fill    <= '0;
         pat     <= '0;
         len     <= '0;
         ovl     <= 1'b0;
         match   <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         hist    <= hist_nxt;
         fill    <= fill_nxt;
         pat     <= pat_nxt;
         len     <= len_nxt;
         ovl     <= ovl_nxt;
         match   <= match_nxt;
         cfg_err <= cfg_err_nxt;
      end
   end

   assign armed = (state != IDLE);

   sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (cnt_inc),
      .clr (cnt_clr),
      .cnt (match_count)
   );

endmodule

// File: tb/tb_pattern_detect_prog.sv
// Directed bench for pattern_detect_prog; a second instance with a 2-bit counter shares the stimulus.
module tb_pattern_detect_prog;

   logic        clk;
   logic        rst;
   logic        cfg_wr;
   logic [7:0]  cfg_pattern;
   logic [3:0]  cfg_len;
   logic        cfg_overlap;
   logic        in_valid;
   logic        in_bit;
   logic        match, cfg_err, armed;
   logic [15:0] match_count;
   logic        match2, cfg_err2, armed2;
   logic [1:0]  match_count2;

   int errors = 0;
   int checks = 0;

   pattern_detect_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_bit(in_bit), .match(match), .match_count(match_count),
      .cfg_err(cfg_err), .armed(armed)
   );

   pattern_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
      .in_bit(in_bit), .match(match2), .match_count(match_count2),
      .cfg_err(cfg_err2), .armed(armed2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
      cfg_wr = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      tick();
      cfg_wr = 1'b0;
   endtask

   // One valid bit, then check the match pulse registered by that edge.
   task automatic send(input logic b, input logic exp_match, input string tag);
      in_valid = 1'b1; in_bit = b;
      tick();
      in_valid = 1'b0;
      chk(tag, {31'd0, match}, {31'd0, exp_match});
   endtask

   initial begin
      rst = 1'b0; cfg_wr = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      tick(); tick();
      chk("rst_match", {31'd0, match}, 32'd0);
      chk("rst_count", {16'd0, match_count}, 32'd0);
      chk("rst_armed", {31'd0, armed}, 32'd0);
      chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
      rst = 1'b1;
      tick();

      // IDLE ignores data.
      send(1'b1, 1'b0, "idle_bit");
      chk("idle_armed", {31'd0, armed}, 32'd0);

      // Overlap mode: 1,0,0,1,0,0,1,0 matches after bits 5 and 8.
      do_cfg(8'h12, 4'd5, 1'b1);
      chk("cfg_armed", {31'd0, armed}, 32'd1);
      send(1, 0, "ov_b1"); send(0, 0, "ov_b2"); send(0, 0, "ov_b3"); send(1, 0, "ov_b4");
      send(0, 1, "ov_b5"); send(0, 0, "ov_b6"); send(1, 0, "ov_b7"); send(0, 1, "ov_b8");
      tick();
      chk("ov_pulse_end", {31'd0, match}, 32'd0);
      chk("ov_count", {16'd0, match_count}, 32'd2);

      // Non-overlap mode: only bit 5 matches.
      do_cfg(8'h12, 4'd5, 1'b0);
      chk("nov_count_clr", {16'd0, match_count}, 32'd0);
      send(1, 0, "nov_b1"); send(0, 0, "nov_b2"); send(0, 0, "nov_b3"); send(1, 0, "nov_b4");
      send(0, 1, "nov_b5"); send(0, 0, "nov_b6"); send(1, 0, "nov_b7"); send(0, 0, "nov_b8");
      chk("nov_count", {16'd0, match_count}, 32'd1);

      // Gapped stream: three idle cycles between valid bits.
      do_cfg(8'h12, 4'd5, 1'b1);
      send(1, 0, "gap_b1"); tick(); tick(); tick();
      send(0, 0, "gap_b2"); tick(); tick(); tick();
      send(0, 0, "gap_b3"); tick(); tick(); tick();
      send(1, 0, "gap_b4"); tick(); tick(); tick();
      chk("gap_pre", {31'd0, match}, 32'd0);
      send(0, 1, "gap_b5");
      tick();
      chk("gap_after", {31'd0, match}, 32'd0);
      tick(); tick();
      chk("gap_count", {16'd0, match_count}, 32'd1);

      // Rejected configurations.
      do_cfg(8'hFF, 4'd0, 1'b0);
      chk("err_len0", {31'd0, cfg_err}, 32'd1);
      chk("err_len0_armed", {31'd0, armed}, 32'd1);
      tick();
      chk("err_len0_pulse", {31'd0, cfg_err}, 32'd0);
      do_cfg(8'hFF, 4'd9, 1'b0);
      chk("err_len9", {31'd0, cfg_err}, 32'd1);
      chk("err_count_kept", {16'd0, match_count}, 32'd1);
      // Old config, history and overlap retained: 0,1,0 completes another 10010.
      send(0, 0, "keep_b1"); send(1, 0, "keep_b2"); send(0, 1, "keep_b3");
      chk("keep_count", {16'd0, match_count}, 32'd2);

      // cfg_wr with in_valid in the same cycle: that bit is dropped.
      cfg_wr = 1'b1; cfg_pattern = 8'h12; cfg_len = 4'd5; cfg_overlap = 1'b1;
      in_valid = 1'b1; in_bit = 1'b1;
      tick();
      cfg_wr = 1'b0; in_valid = 1'b0;
      send(0, 0, "drop_b1"); send(0, 0, "drop_b2"); send(1, 0, "drop_b3"); send(0, 0, "drop_b4");
      chk("drop_count", {16'd0, match_count}, 32'd0);

      // Length 1, five 1s: every bit matches; 2-bit counter saturates at 3.
      do_cfg(8'h01, 4'd1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send(1, 1, "len1_match");
         chk("len1_match2", {31'd0, match2}, 32'd1);
      end
      chk("len1_count16", {16'd0, match_count}, 32'd5);
      chk("len1_count2", {30'd0, match_count2}, 32'd3);

      // Mid-stream reset discards configuration and partial match.
      do_cfg(8'h12, 4'd5, 1'b1);
      send(1, 0, "rs_b1"); send(0, 0, "rs_b2"); send(0, 0, "rs_b3");
      rst = 1'b0;
      #1;
      chk("rs_armed", {31'd0, armed}, 32'd0);
      chk("rs_count", {16'd0, match_count}, 32'd0);
      tick(); tick();
      chk("rs_match", {31'd0, match}, 32'd0);
      chk("rs_cfg_err", {31'd0, cfg_err}, 32'd0);
      rst = 1'b1;
      tick();
      send(1, 0, "post_b1"); send(0, 0, "post_b2"); send(0, 0, "post_b3");
      send(1, 0, "post_b4"); send(0, 0, "post_b5");
      chk("post_armed", {31'd0, armed}, 32'd0);
      chk("post_count", {16'd0, match_count}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
